// File: rtl/mem_fifo_ctrl.sv
// Valid/ready FIFO controller driving a pseudo-2-port memory (0-cycle read, posedge write).
// Occupancy, pointers and a 3-state FSM live here; storage lives in the external memory.
module mem_fifo_ctrl #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int ALMOST_FULL = 6,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    mem_read_addr,
  input  logic [WIDTH-1:0] mem_qout,
  output logic [AW-1:0]    mem_write_addr,
  output logic [WIDTH-1:0] mem_din,
  output logic             mem_write_en,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          almost_full_q, almost_full_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_udf_q, err_udf_d;
  logic          push_s, pop_s;

  // Handshake decode; flush blocks both sides for its cycle.
  always_comb begin
    in_ready  = (state_q != ST_FULL) && !flush;
    out_valid = (state_q != ST_EMPTY) && !flush;
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
  end

  // Write strobe is gated by reset so the memory is never written while reset is held.
  assign mem_write_en   = push_s && arst_n_in;
  assign mem_write_addr = wr_ptr_q;
  assign mem_din        = in_data;
  assign mem_read_addr  = rd_ptr_q;
  assign out_data       = mem_qout;
  assign count          = count_q;
  assign almost_full    = almost_full_q;
  assign err_ovf        = err_ovf_q;
  assign err_udf        = err_udf_q;

  // Next-state computation for pointers, occupancy, FSM and sticky error flags.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ovf_d = err_ovf_q || (in_valid && (state_q == ST_FULL));
    err_udf_d = err_udf_q || (out_ready && (state_q == ST_EMPTY));
    if (flush) begin
      state_d  = ST_EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap compare keeps non-power-of-2 depths correct.
      if (push_s) begin
        wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case (state_q)
        ST_EMPTY: begin
          if (push_s) state_d = ST_PARTIAL;
          else        state_d = ST_EMPTY;
        end
        ST_PARTIAL: begin
          if (push_s && !pop_s && (count_q == CW'(DEPTH - 1)))     state_d = ST_FULL;
          else if (pop_s && !push_s && (count_q == CW'(1)))        state_d = ST_EMPTY;
          else                                                     state_d = ST_PARTIAL;
        end
        ST_FULL: begin
          if (pop_s) state_d = ST_PARTIAL;
          else       state_d = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    almost_full_d = (count_d >= CW'(ALMOST_FULL));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q       <= ST_EMPTY;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_udf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
      err_ovf_q     <= err_ovf_d;
      err_udf_q     <= err_udf_d;
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: DEPTH=8 and DEPTH=5 instances share stimulus and are
// checked every cycle against a queue-based FIFO model.
module tb_mem_fifo_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         arst_n_in, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         ir [2], ov [2], we [2], af [2], ovf [2], udf [2];
  logic [W-1:0] od [2], qo [2], din [2];
  logic [2:0]   ra [2], wa [2];
  logic [3:0]   cnt0;
  logic [2:0]   cnt1;
  logic [3:0]   obs_cnt [2];
  logic [W-1:0] mem0 [8];
  logic [W-1:0] mem1 [8];

  assign obs_cnt[0] = cnt0;
  assign obs_cnt[1] = {1'b0, cnt1};

  always @(posedge clk) if (we[0]) mem0[wa[0]] <= din[0];
  always @(posedge clk) if (we[1]) mem1[wa[1]] <= din[1];
  assign qo[0] = mem0[ra[0]];
  assign qo[1] = mem1[ra[1]];

  mem_fifo_ctrl #(.WIDTH(W), .DEPTH(8), .ALMOST_FULL(6)) u_dut8 (
    .clk(clk), .arst_n_in(arst_n_in), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .mem_read_addr(ra[0]), .mem_qout(qo[0]), .mem_write_addr(wa[0]),
    .mem_din(din[0]), .mem_write_en(we[0]), .count(cnt0),
    .almost_full(af[0]), .err_ovf(ovf[0]), .err_udf(udf[0]));

  mem_fifo_ctrl #(.WIDTH(W), .DEPTH(5), .ALMOST_FULL(4)) u_dut5 (
    .clk(clk), .arst_n_in(arst_n_in), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .mem_read_addr(ra[1]), .mem_qout(qo[1]), .mem_write_addr(wa[1]),
    .mem_din(din[1]), .mem_write_en(we[1]), .count(cnt1),
    .almost_full(af[1]), .err_ovf(ovf[1]), .err_udf(udf[1]));

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per instance plus modular pointer positions.
  logic [W-1:0] mq0 [$];
  logic [W-1:0] mq1 [$];
  int dep [2] = '{8, 5};
  int afl [2] = '{6, 4};
  int wp_m [2];
  int rp_m [2];
  logic ovf_m [2];
  logic udf_m [2];

  function automatic int msize(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [W-1:0] mfront(input int d);
    return (d == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    for (int d = 0; d < 2; d++) begin
      wp_m[d] = 0; rp_m[d] = 0; ovf_m[d] = 1'b0; udf_m[d] = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] dat, input logic rdy, input logic fl);
    int   sz [2];
    logic e_push [2];
    logic e_pop [2];
    in_valid = v; in_data = dat; out_ready = rdy; flush = fl;
    #2;
    for (int d = 0; d < 2; d++) begin
      logic e_ir, e_ov;
      sz[d]     = msize(d);
      e_ir      = (sz[d] != dep[d]) && !fl;
      e_ov      = (sz[d] != 0) && !fl;
      e_push[d] = v && e_ir;
      e_pop[d]  = e_ov && rdy;
      total += 8;
      if (ir[d] !== e_ir) begin bad++; $display("FAIL in_ready dut%0d t=%0t got %b want %b", d, $time, ir[d], e_ir); end
      if (ov[d] !== e_ov) begin bad++; $display("FAIL out_valid dut%0d t=%0t got %b want %b", d, $time, ov[d], e_ov); end
      if (we[d] !== e_push[d]) begin bad++; $display("FAIL write_en dut%0d t=%0t got %b want %b", d, $time, we[d], e_push[d]); end
      if (ra[d] !== 3'(rp_m[d])) begin bad++; $display("FAIL read_addr dut%0d t=%0t got %0d want %0d", d, $time, ra[d], rp_m[d]); end
      if (obs_cnt[d] !== 4'(sz[d])) begin bad++; $display("FAIL count dut%0d t=%0t got %0d want %0d", d, $time, obs_cnt[d], sz[d]); end
      if (af[d] !== (sz[d] >= afl[d])) begin bad++; $display("FAIL almost_full dut%0d t=%0t got %b want %b", d, $time, af[d], sz[d] >= afl[d]); end
      if (ovf[d] !== ovf_m[d]) begin bad++; $display("FAIL err_ovf dut%0d t=%0t got %b want %b", d, $time, ovf[d], ovf_m[d]); end
      if (udf[d] !== udf_m[d]) begin bad++; $display("FAIL err_udf dut%0d t=%0t got %b want %b", d, $time, udf[d], udf_m[d]); end
      if (e_push[d]) begin
        total += 2;
        if (wa[d] !== 3'(wp_m[d])) begin bad++; $display("FAIL write_addr dut%0d t=%0t got %0d want %0d", d, $time, wa[d], wp_m[d]); end
        if (din[d] !== dat) begin bad++; $display("FAIL mem_din dut%0d t=%0t got %h want %h", d, $time, din[d], dat); end
      end
      if (e_ov) begin
        total++;
        if (od[d] !== mfront(d)) begin bad++; $display("FAIL out_data dut%0d t=%0t got %h want %h", d, $time, od[d], mfront(d)); end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (v && (sz[d] == dep[d])) ovf_m[d] = 1'b1;
      if (rdy && (sz[d] == 0))    udf_m[d] = 1'b1;
      if (fl) begin
        if (d == 0) mq0.delete(); else mq1.delete();
        wp_m[d] = 0; rp_m[d] = 0;
      end else begin
        if (e_pop[d]) begin
          if (d == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
          rp_m[d] = (rp_m[d] + 1) % dep[d];
        end
        if (e_push[d]) begin
          if (d == 0) mq0.push_back(dat); else mq1.push_back(dat);
          wp_m[d] = (wp_m[d] + 1) % dep[d];
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    arst_n_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    @(posedge clk);
    @(negedge clk);
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0; in_valid = 1'b1; in_data = 16'h5A5A; out_ready = 1'b1; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      for (int d = 0; d < 2; d++) begin
        total += 6;
        if (ir[d] !== 1'b1) begin bad++; $display("FAIL reset_in_ready dut%0d got %b want 1", d, ir[d]); end
        if (ov[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d got %b want 0", d, ov[d]); end
        if (we[d] !== 1'b0) begin bad++; $display("FAIL reset_write_en dut%0d got %b want 0", d, we[d]); end
        if (obs_cnt[d] !== 4'd0) begin bad++; $display("FAIL reset_count dut%0d got %0d want 0", d, obs_cnt[d]); end
        if (af[d] !== 1'b0) begin bad++; $display("FAIL reset_almost_full dut%0d got %b want 0", d, af[d]); end
        if ({ovf[d], udf[d]} !== 2'b00) begin bad++; $display("FAIL reset_err dut%0d got %b%b want 00", d, ovf[d], udf[d]); end
      end
      @(posedge clk);
    end
    do_reset();
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    #1;
    total += 3;
    if (cnt0 !== 4'd8) begin bad++; $display("FAIL fill_count got %0d want 8", cnt0); end
    if (ir[0] !== 1'b0) begin bad++; $display("FAIL fill_in_ready got %b want 0", ir[0]); end
    if (af[0] !== 1'b1) begin bad++; $display("FAIL fill_almost_full got %b want 1", af[0]); end
    for (int i = 1; i <= 8; i++) begin
      #1;
      total++;
      if (od[0] !== 16'(i)) begin bad++; $display("FAIL drain_order got %h want %h", od[0], 16'(i)); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    total += 3;
    if (cnt0 !== 4'd0) begin bad++; $display("FAIL drain_count got %0d want 0", cnt0); end
    if (ov[0] !== 1'b0) begin bad++; $display("FAIL drain_out_valid got %b want 0", ov[0]); end
    if ({ovf[0], udf[0]} !== 2'b00) begin bad++; $display("FAIL drain_err got %b%b want 00", ovf[0], udf[0]); end
  endtask

  task automatic test_stream_wrap();
    logic [2:0] prev;
    logic       saw_wrap;
    do_reset();
    saw_wrap = 1'b0;
    for (int i = 0; i < 12; i++) begin
      prev = wa[1];
      step(1'b1, 16'($urandom), 1'b1, 1'b0);
      if ((prev == 3'd4) && (wa[1] == 3'd0)) saw_wrap = 1'b1;
    end
    total += 2;
    if (saw_wrap !== 1'b1) begin bad++; $display("FAIL stream_wrap got %b want 1", saw_wrap); end
    if (cnt1 !== 3'd1) begin bad++; $display("FAIL stream_count got %0d want 1", cnt1); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    total += 2;
    if (cnt0 !== 4'd0) begin bad++; $display("FAIL flush_count got %0d want 0", cnt0); end
    if (ov[0] !== 1'b0) begin bad++; $display("FAIL flush_out_valid got %b want 0", ov[0]); end
  endtask

  task automatic test_errors();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    total++;
    if (ovf[0] !== 1'b1) begin bad++; $display("FAIL err_ovf_set got %b want 1", ovf[0]); end
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    total++;
    if (udf[0] !== 1'b1) begin bad++; $display("FAIL err_udf_set got %b want 1", udf[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
    arst_n_in = 1'b0; in_valid = 1'b1;
    #1;
    total += 4;
    if (cnt0 !== 4'd0) begin bad++; $display("FAIL midrst_count got %0d want 0", cnt0); end
    if (ir[0] !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got %b want 1", ir[0]); end
    if (ov[0] !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got %b want 0", ov[0]); end
    if (we[0] !== 1'b0) begin bad++; $display("FAIL midrst_write_en got %b want 0", we[0]); end
    do_reset();
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    total++;
    if (od[0] !== 16'hBEEF) begin bad++; $display("FAIL midrst_first_word got %h want beef", od[0]); end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3, 0) != 0), 16'($urandom), ($urandom_range(1, 0) == 1),
           ($urandom_range(24, 0) == 0));
    end
  endtask

  initial begin
    arst_n_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_stream_wrap();
    test_flush();
    test_errors();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
